// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin timeout arbiter: FSM state,
// default widths and the flit type that marks a packet header.
package arbiter_pkg;

  localparam int NPORTS_DEF    = 5;
  localparam int LEN_W_DEF     = 12;
  localparam int FLIT_ID_W_DEF = 3;

  localparam logic [FLIT_ID_W_DEF-1:0] HEADER_ID = 3'b001;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage : arbiter_pkg

// File: rtl/port_timer.sv
// Per-port packet timer: latches the length carried by each header flit and
// counts how long the port has held the grant, flagging when it has used up its slot.
module port_timer #(
  parameter int                   LEN_W     = 12,
  parameter int                   FLIT_ID_W = 3,
  parameter logic [FLIT_ID_W-1:0] HEADER_ID = 3'b001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_ID_W-1:0] flit_id_i,
  input  logic [LEN_W-1:0]     length_i,
  input  logic                 grant_i,    // port holds the grant in the coming cycle
  output logic                 timesup_o
);

  logic [LEN_W-1:0] limit_q;
  logic [LEN_W-1:0] count_q;

  // NOTE: non-blocking assignments for every flop, so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit_q <= '0;
      count_q <= '0;
    end else begin
      if (flit_id_i == HEADER_ID) begin
        limit_q <= length_i;
      end
      // count is the number of cycles of the current grant, including the coming one
      if (!grant_i) begin
        count_q <= '0;
      end else if (count_q != '1) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign timesup_o = (limit_q != '0) && (count_q >= limit_q);

endmodule : port_timer

// File: rtl/rr_timeout_arbiter.sv
// Round-robin arbiter with a per-port grant time limit taken from header flits;
// a port that overruns its limit is preempted in favour of the next requester.
module rr_timeout_arbiter
  import arbiter_pkg::*;
#(
  parameter int                   NPORTS    = NPORTS_DEF,
  parameter int                   LEN_W     = LEN_W_DEF,
  parameter int                   FLIT_ID_W = FLIT_ID_W_DEF,
  parameter logic [FLIT_ID_W-1:0] HEADER_ID = FLIT_ID_W'(arbiter_pkg::HEADER_ID)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORTS-1:0]           req,
  input  logic [NPORTS*FLIT_ID_W-1:0] flit_id,
  input  logic [NPORTS*LEN_W-1:0]     length,
  output logic [NPORTS-1:0]           grant,
  output logic                        grant_valid,
  output logic [$clog2(NPORTS)-1:0]   grant_idx,
  output logic                        timeout
);

  localparam int IDX_W = $clog2(NPORTS);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              grant_valid_q;
  logic              timeout_q, timeout_d;

  logic [NPORTS-1:0] timesup;
  logic [NPORTS-1:0] cand;
  logic [IDX_W-1:0]  start;
  logic              rearb;
  logic [IDX_W:0]    pick;

  function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NPORTS - 1)) ? '0 : i + 1'b1;
  endfunction

  // First candidate at or after start, wrapping; returns {found, index}.
  function automatic logic [IDX_W:0] rr_select(input logic [NPORTS-1:0] c,
                                               input logic [IDX_W-1:0]  s);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               p;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      p = int'(s) + k;
      if (p >= NPORTS) p = p - NPORTS;
      if (!found && c[p]) begin
        found = 1'b1;
        idx   = IDX_W'(p);
      end
    end
    return {found, idx};
  endfunction

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    timeout_d   = 1'b0;
    cand        = req;
    start       = ptr_q;
    rearb       = 1'b0;
    pick        = '0;

    case (state_q)
      BUSY: begin
        if (!req[grant_idx_q]) begin
          ptr_d = next_port(grant_idx_q);
          start = next_port(grant_idx_q);
          rearb = 1'b1;
        end else if (timesup[grant_idx_q]) begin
          // the preempted port sits out exactly one arbitration round
          timeout_d          = 1'b1;
          ptr_d              = next_port(grant_idx_q);
          start              = next_port(grant_idx_q);
          cand[grant_idx_q]  = 1'b0;
          rearb              = 1'b1;
        end
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      pick = rr_select(cand, start);
      if (pick[IDX_W]) begin
        state_d     = BUSY;
        grant_idx_d = pick[IDX_W-1:0];
        grant_d     = NPORTS'(1) << pick[IDX_W-1:0];
      end else begin
        state_d     = IDLE;
        grant_idx_d = '0;
        grant_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= (state_d == BUSY);
      timeout_q     <= timeout_d;
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    port_timer #(
      .LEN_W     (LEN_W),
      .FLIT_ID_W (FLIT_ID_W),
      .HEADER_ID (HEADER_ID)
    ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .flit_id_i (flit_id[p*FLIT_ID_W +: FLIT_ID_W]),
      .length_i  (length[p*LEN_W +: LEN_W]),
      .grant_i   (grant_d[p]),
      .timesup_o (timesup[p])
    );
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign timeout     = timeout_q;

endmodule : rr_timeout_arbiter

// File: tb/tb_rr_timeout_arbiter.sv
// Scoreboard bench for rr_timeout_arbiter (5 ports, 12-bit lengths): directed
// per-cycle stimulus queues the expected grant; a monitor pops and compares.
module tb_rr_timeout_arbiter;

  localparam int NP = 5;
  localparam int LW = 12;
  localparam int FW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req;
  logic [NP*FW-1:0] flit_id;
  logic [NP*LW-1:0] length;
  logic [NP-1:0]    grant;
  logic             grant_valid;
  logic [2:0]       grant_idx;
  logic             timeout;

  typedef struct {
    logic [NP-1:0] grant;
    logic          timeout;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  rr_timeout_arbiter #(
    .NPORTS    (NP),
    .LEN_W     (LW),
    .FLIT_ID_W (FW),
    .HEADER_ID (3'b001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .length      (length),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot_idx(input logic [NP-1:0] g);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < NP; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input logic [NP-1:0] r, input logic [NP-1:0] hdr_mask,
                      input logic [LW-1:0] len, input logic [NP-1:0] eg,
                      input logic eto, input string nm);
    exp_t e;
    @(negedge clk);
    req = r;
    for (int p = 0; p < NP; p++) begin
      flit_id[p*FW +: FW] = hdr_mask[p] ? 3'b001 : 3'b010;
      length[p*LW +: LW]  = len;
    end
    e.grant   = eg;
    e.timeout = eto;
    e.name    = nm;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    req     = '0;
    flit_id = '0;
    length  = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compare every presented output cycle against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      check("onehot0", 32'($onehot0(grant)), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, "/grant"},   32'(grant),       32'(e.grant));
        check({e.name, "/valid"},   32'(grant_valid), 32'(|e.grant));
        check({e.name, "/idx"},     32'(grant_idx),   onehot_idx(e.grant));
        check({e.name, "/timeout"}, 32'(timeout),     32'(e.timeout));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    req     = '0;
    flit_id = '0;
    length  = '0;
    #1;
    check("rst/grant",   32'(grant),       32'd0);
    check("rst/valid",   32'(grant_valid), 32'd0);
    check("rst/idx",     32'(grant_idx),   32'd0);
    check("rst/timeout", 32'(timeout),     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic round robin: handoff without bubble and pointer wrap.
    step(5'b10100, 5'b0, 12'd0, 5'b00100, 1'b0, "first");
    step(5'b10000, 5'b0, 12'd0, 5'b10000, 1'b0, "handoff");
    step(5'b00000, 5'b0, 12'd0, 5'b00000, 1'b0, "idle");
    step(5'b00011, 5'b0, 12'd0, 5'b00001, 1'b0, "wrap_p0");
    step(5'b00010, 5'b0, 12'd0, 5'b00010, 1'b0, "to_p1");
    step(5'b00001, 5'b0, 12'd0, 5'b00001, 1'b0, "scan_wrap");
    step(5'b00000, 5'b0, 12'd0, 5'b00000, 1'b0, "idle2");

    // Single requester with limit 4: 4 granted cycles, timeout, bubble, regrant.
    do_reset();
    step(5'b00010, 5'b00010, 12'd4, 5'b00010, 1'b0, "lim4_c0");
    for (int k = 0; k < 3; k++) step(5'b00010, 5'b0, 12'd0, 5'b00010, 1'b0, "lim4_hold");
    step(5'b00010, 5'b0, 12'd0, 5'b00000, 1'b1, "lim4_to");
    for (int k = 0; k < 4; k++) step(5'b00010, 5'b0, 12'd0, 5'b00010, 1'b0, "lim4_regrant");
    step(5'b00010, 5'b0, 12'd0, 5'b00000, 1'b1, "lim4_to2");

    // Header mid-grant raises the limit to 5 without clearing the count.
    do_reset();
    step(5'b00100, 5'b00100, 12'd3, 5'b00100, 1'b0, "mid_c0");
    step(5'b00100, 5'b0,     12'd0, 5'b00100, 1'b0, "mid_c1");
    step(5'b00100, 5'b00100, 12'd5, 5'b00100, 1'b0, "mid_c2");
    step(5'b00100, 5'b0,     12'd0, 5'b00100, 1'b0, "mid_c3");
    step(5'b00100, 5'b0,     12'd0, 5'b00100, 1'b0, "mid_c4");
    step(5'b00100, 5'b0,     12'd0, 5'b00000, 1'b1, "mid_to");

    // All ports requesting with limit 2: rotation every two cycles.
    do_reset();
    step(5'b00000, 5'b11111, 12'd2, 5'b00000, 1'b0, "rot_load");
    step(5'b11111, 5'b0, 12'd0, 5'b00001, 1'b0, "rot_p0a");
    step(5'b11111, 5'b0, 12'd0, 5'b00001, 1'b0, "rot_p0b");
    step(5'b11111, 5'b0, 12'd0, 5'b00010, 1'b1, "rot_p1a");
    step(5'b11111, 5'b0, 12'd0, 5'b00010, 1'b0, "rot_p1b");
    step(5'b11111, 5'b0, 12'd0, 5'b00100, 1'b1, "rot_p2a");
    step(5'b11111, 5'b0, 12'd0, 5'b00100, 1'b0, "rot_p2b");
    step(5'b11111, 5'b0, 12'd0, 5'b01000, 1'b1, "rot_p3a");
    step(5'b11111, 5'b0, 12'd0, 5'b01000, 1'b0, "rot_p3b");
    step(5'b11111, 5'b0, 12'd0, 5'b10000, 1'b1, "rot_p4a");
    step(5'b11111, 5'b0, 12'd0, 5'b10000, 1'b0, "rot_p4b");
    step(5'b11111, 5'b0, 12'd0, 5'b00001, 1'b1, "rot_p0c");
    step(5'b11111, 5'b0, 12'd0, 5'b00001, 1'b0, "rot_p0d");

    // Limit 0 disables the timeout even past count saturation.
    do_reset();
    step(5'b01000, 5'b01000, 12'd0, 5'b01000, 1'b0, "nolim_c0");
    for (int k = 0; k < 5000; k++) step(5'b01000, 5'b0, 12'd0, 5'b01000, 1'b0, "nolim_hold");

    // Asynchronous reset mid-grant, then restart from port 0 with limits cleared.
    do_reset();
    step(5'b10000, 5'b11111, 12'd2, 5'b10000, 1'b0, "ar_c0");
    step(5'b10000, 5'b0,     12'd0, 5'b10000, 1'b0, "ar_c1");
    @(posedge clk);
    #3;
    rst     = 1'b0;
    req     = '0;
    flit_id = '0;
    #1;
    check("async_rst/grant",   32'(grant),       32'd0);
    check("async_rst/valid",   32'(grant_valid), 32'd0);
    check("async_rst/idx",     32'(grant_idx),   32'd0);
    check("async_rst/timeout", 32'(timeout),     32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) step(5'b11111, 5'b0, 12'd0, 5'b00001, 1'b0, "ar_restart");

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_timeout_arbiter
